// File: rtl/cmd_decoder_if.sv
// Bus bundle between the Fetcher, the command decoder and the execute stage.
// The slave modport is the decoder's view; the master modport is the environment's view.
interface cmd_decoder_if;
    // fetch side
    logic [95:0] cmdInfo;
    logic        cmdValid;
    logic        cmdReady;
    logic        readNextCmdFlag;
    logic [1:0]  prevCmdSize;
    logic        addrChangeFlag;
    logic [31:0] newAddrOff;
    // execute side
    logic        decValid;
    logic        decReady;
    logic [31:0] decAddr;
    logic [1:0]  decClass;
    logic [3:0]  decOpcode;
    logic [1:0]  decSize;
    logic [31:0] decImm;
    // status
    logic        halted;
    logic [31:0] cmdCount;
    logic [15:0] jumpCount;

    modport slave (
        input  cmdInfo, cmdValid, decReady,
        output cmdReady, readNextCmdFlag, prevCmdSize, addrChangeFlag, newAddrOff,
               decValid, decAddr, decClass, decOpcode, decSize, decImm,
               halted, cmdCount, jumpCount
    );

    modport master (
        output cmdInfo, cmdValid, decReady,
        input  cmdReady, readNextCmdFlag, prevCmdSize, addrChangeFlag, newAddrOff,
               decValid, decAddr, decClass, decOpcode, decSize, decImm,
               halted, cmdCount, jumpCount
    );
endinterface

// File: rtl/cmd_decoder.sv
// Command decoder: sizes and decodes one command per handshake from the
// Fetcher window, feeds advance/redirect pulses back to the Fetcher, drops
// the FLUSH_DEPTH stale beats after a jump, and parks forever on HALT.
// Optional emitted-command statistics are built when DEC_STATS_EN is defined.
module cmd_decoder #(
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input logic          clk,
    input logic          rst,
    cmd_decoder_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_e;

    localparam logic [1:0] CLS_JUMP   = 2'b10;
    localparam logic [1:0] CLS_HALT   = 2'b11;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        dec_valid_q, dec_valid_d;
    logic [31:0] dec_addr_q, dec_addr_d;
    logic [1:0]  dec_class_q, dec_class_d;
    logic [3:0]  dec_opcode_q, dec_opcode_d;
    logic [1:0]  dec_size_q, dec_size_d;
    logic [31:0] dec_imm_q, dec_imm_d;
    logic        rnc_q, rnc_d;
    logic [1:0]  prev_size_q, prev_size_d;
    logic        addr_chg_q, addr_chg_d;
    logic [31:0] new_off_q, new_off_d;
    logic        halted_q, halted_d;

    logic        cmd_ready, accept, load;
    logic [1:0]  in_class, in_size;
    logic [3:0]  in_opcode;
    logic [31:0] in_imm;

    // Field extraction from the fetch window; bytes past the command size are ignored
    always_comb begin
        in_opcode = bus.cmdInfo[3:0];
        in_class  = bus.cmdInfo[5:4];
        in_size   = bus.cmdInfo[7:6];
        unique case (in_size)
            2'b00:   in_imm = 32'd0;
            2'b01:   in_imm = {{24{bus.cmdInfo[15]}}, bus.cmdInfo[15:8]};
            2'b10:   in_imm = {{8{bus.cmdInfo[31]}}, bus.cmdInfo[31:8]};
            default: in_imm = bus.cmdInfo[63:32];
        endcase
    end

    // FLUSH swallows beats unconditionally; RUN only takes a beat when the output slot frees
    always_comb begin
        cmd_ready = ((state_q == RUN) && (!dec_valid_q || bus.decReady)) || (state_q == FLUSH);
        accept    = bus.cmdValid && cmd_ready;
        load      = accept && (state_q == RUN);
    end

    // Next-state and output-register logic
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        dec_valid_d  = dec_valid_q && !bus.decReady;
        dec_addr_d   = dec_addr_q;
        dec_class_d  = dec_class_q;
        dec_opcode_d = dec_opcode_q;
        dec_size_d   = dec_size_q;
        dec_imm_d    = dec_imm_q;
        rnc_d        = 1'b0;
        addr_chg_d   = 1'b0;
        prev_size_d  = prev_size_q;
        new_off_d    = new_off_q;
        // halted flags only once the HALT itself has been taken by execute
        halted_d     = halted_q || (dec_valid_q && bus.decReady && (dec_class_q == CLS_HALT));

        if (load) begin
            dec_valid_d  = 1'b1;
            dec_addr_d   = bus.cmdInfo[95:64];
            dec_class_d  = in_class;
            dec_opcode_d = in_opcode;
            dec_size_d   = in_size;
            dec_imm_d    = in_imm;
            prev_size_d  = in_size;
            rnc_d        = (in_class != CLS_HALT);
            if (in_class == CLS_JUMP) begin
                addr_chg_d = 1'b1;
                new_off_d  = in_imm;
                if (FLUSH_DEPTH != 0) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end else if (in_class == CLS_HALT) begin
                state_d = HALTED;
            end
        end

        // stale beats already in flight from the old fetch address are dropped
        if (accept && (state_q == FLUSH)) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) state_d = RUN;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_cnt_q  <= 3'd0;
            dec_valid_q  <= 1'b0;
            dec_addr_q   <= 32'd0;
            dec_class_q  <= 2'd0;
            dec_opcode_q <= 4'd0;
            dec_size_q   <= 2'd0;
            dec_imm_q    <= 32'd0;
            rnc_q        <= 1'b0;
            prev_size_q  <= 2'd0;
            addr_chg_q   <= 1'b0;
            new_off_q    <= 32'd0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            dec_valid_q  <= dec_valid_d;
            dec_addr_q   <= dec_addr_d;
            dec_class_q  <= dec_class_d;
            dec_opcode_q <= dec_opcode_d;
            dec_size_q   <= dec_size_d;
            dec_imm_q    <= dec_imm_d;
            rnc_q        <= rnc_d;
            prev_size_q  <= prev_size_d;
            addr_chg_q   <= addr_chg_d;
            new_off_q    <= new_off_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.cmdReady        = cmd_ready;
    assign bus.readNextCmdFlag = rnc_q;
    assign bus.prevCmdSize     = prev_size_q;
    assign bus.addrChangeFlag  = addr_chg_q;
    assign bus.newAddrOff      = new_off_q;
    assign bus.decValid        = dec_valid_q;
    assign bus.decAddr         = dec_addr_q;
    assign bus.decClass        = dec_class_q;
    assign bus.decOpcode       = dec_opcode_q;
    assign bus.decSize         = dec_size_q;
    assign bus.decImm          = dec_imm_q;
    assign bus.halted          = halted_q;

`ifdef DEC_STATS_EN
    logic [31:0] cmd_cnt_q, cmd_cnt_d;
    logic [15:0] jump_cnt_q, jump_cnt_d;

    // Count every command taken by execute, and separately the jumps
    always_comb begin
        cmd_cnt_d  = cmd_cnt_q;
        jump_cnt_d = jump_cnt_q;
        if (dec_valid_q && bus.decReady) begin
            cmd_cnt_d = cmd_cnt_q + 32'd1;
            if (dec_class_q == CLS_JUMP) jump_cnt_d = jump_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt_q  <= 32'd0;
            jump_cnt_q <= 16'd0;
        end else begin
            cmd_cnt_q  <= cmd_cnt_d;
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign bus.cmdCount  = cmd_cnt_q;
    assign bus.jumpCount = jump_cnt_q;
`else
    assign bus.cmdCount  = 32'd0;
    assign bus.jumpCount = 16'd0;
`endif
endmodule
